// File: rtl/pipe_sub32.sv
// Four-stage pipelined 32-bit subtractor: d = a - b - bi, one 8-bit CLA slice per stage.
// Upper operand bytes ride down the pipe beside the carry; finished low bytes accumulate behind it.
module pipe_sub32 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_valid,
  input  logic        i_hold,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_bi,
  output logic        o_valid,
  output logic [31:0] o_d,
  output logic        o_bo,
  output logic        o_zero,
  output logic        o_ovf
);

  // 8-bit carry-lookahead slice of x + y + cin; returns {cout, sum}
  function automatic logic [8:0] cla8(input logic [7:0] x, input logic [7:0] y, input logic cin);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      term = cin;
      for (int k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
    return {c[8], p ^ c[7:0]};
  endfunction

  logic        r1_v, r2_v, r3_v, r4_v;
  logic        r1_c, r2_c, r3_c, r4_c;
  logic [7:0]  r1_d;
  logic [15:0] r2_d;
  logic [23:0] r3_d;
  logic [31:0] r4_d;
  logic [31:8] r1_a, r1_nb;
  logic [31:16] r2_a, r2_nb;
  logic [31:24] r3_a, r3_nb;
  logic        r4_ovf;
  logic        r_o_valid, r_o_bo, r_o_zero, r_o_ovf;
  logic [31:0] r_o_d;

  logic [8:0]  w_s0, w_s1, w_s2, w_s3;
  logic        w_ovf;

  assign w_s0  = cla8(i_a[7:0], ~i_b[7:0], ~i_bi);
  assign w_s1  = cla8(r1_a[15:8], r1_nb[15:8], r1_c);
  assign w_s2  = cla8(r2_a[23:16], r2_nb[23:16], r2_c);
  assign w_s3  = cla8(r3_a[31:24], r3_nb[31:24], r3_c);
  // b[31] is recovered from the inverted copy carried alongside a
  assign w_ovf = (r3_a[31] != ~r3_nb[31]) & (w_s3[7] != r3_a[31]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1_v <= 1'b0; r1_c <= 1'b0; r1_d <= '0; r1_a <= '0; r1_nb <= '0;
      r2_v <= 1'b0; r2_c <= 1'b0; r2_d <= '0; r2_a <= '0; r2_nb <= '0;
      r3_v <= 1'b0; r3_c <= 1'b0; r3_d <= '0; r3_a <= '0; r3_nb <= '0;
      r4_v <= 1'b0; r4_c <= 1'b0; r4_d <= '0; r4_ovf <= 1'b0;
      r_o_valid <= 1'b0; r_o_d <= '0; r_o_bo <= 1'b0; r_o_zero <= 1'b0; r_o_ovf <= 1'b0;
    end else if (!i_hold) begin
      r1_v  <= i_valid;
      r1_c  <= w_s0[8];
      r1_d  <= w_s0[7:0];
      r1_a  <= i_a[31:8];
      r1_nb <= ~i_b[31:8];

      r2_v  <= r1_v;
      r2_c  <= w_s1[8];
      r2_d  <= {w_s1[7:0], r1_d};
      r2_a  <= r1_a[31:16];
      r2_nb <= r1_nb[31:16];

      r3_v  <= r2_v;
      r3_c  <= w_s2[8];
      r3_d  <= {w_s2[7:0], r2_d};
      r3_a  <= r2_a[31:24];
      r3_nb <= r2_nb[31:24];

      r4_v   <= r3_v;
      r4_c   <= w_s3[8];
      r4_d   <= {w_s3[7:0], r3_d};
      r4_ovf <= w_ovf;

      r_o_valid <= r4_v;
      r_o_d     <= r4_d;
      r_o_bo    <= ~r4_c;
      r_o_zero  <= (r4_d == 32'd0);
      r_o_ovf   <= r4_ovf;
    end
  end

  assign o_valid = r_o_valid;
  assign o_d     = r_o_d;
  assign o_bo    = r_o_bo;
  assign o_zero  = r_o_zero;
  assign o_ovf   = r_o_ovf;

endmodule
